dpram_sync_clr: RTL and testbench

Second-generation dual-port RAM for the BTLE datapath: one write port and one read port on a single clock, with a registered read pipeline of configurable latency and a valid strobe. A built-in clear engine sweeps the whole array to a programmable value after reset and on request, so packet and CRC buffers start from a known state. It replaces the combinational-read RAM wherever timing or deterministic initial contents are required.

---
 rtl/dpram_sync_clr.sv | 115 +++++++++++
 tb/tb_dpram_sync_clr.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_sync_clr.sv
// Dual-port RAM with registered read pipeline (1 or 2 cycles) and a clear engine.
// Define DPRAM_BYPASS_EN to return write_data on a same-address, same-edge read/write.
module dpram_sync_clr #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDRESS_WIDTH = 11,
  parameter int unsigned READ_LATENCY  = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_req,
  output logic                     busy,
  input  logic                     write_enable,
  input  logic [ADDRESS_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0]    write_data,
  output logic                     write_ready,
  input  logic                     read_enable,
  input  logic [ADDRESS_WIDTH-1:0] read_address,
  output logic                     read_ready,
  output logic [DATA_WIDTH-1:0]    read_data,
  output logic                     read_valid
);

  localparam int unsigned DEPTH = 1 << ADDRESS_WIDTH;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0]    mem [DEPTH];

  logic                     wr_acc, rd_acc;
  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_wa;
  logic [DATA_WIDTH-1:0]    mem_wd;
  logic [DATA_WIDTH-1:0]    rd_word;

  logic                     s1_valid, s2_valid;
  logic [DATA_WIDTH-1:0]    s1_data, s2_data;

  assign busy        = (state_q == CLEAR);
  assign write_ready = ~busy;
  assign read_ready  = ~busy;
  assign wr_acc      = write_enable & ~busy;
  assign rd_acc      = read_enable & ~busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = IDLE;
      end
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // The sweep owns the single write port while busy; user writes are dropped.
  always_comb begin
    mem_we = busy | wr_acc;
    mem_wa = busy ? cnt_q : write_address;
    mem_wd = busy ? CLEAR_VALUE : write_data;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

`ifdef DPRAM_BYPASS_EN
  assign rd_word = (wr_acc && (write_address == read_address)) ? write_data
                                                               : mem[read_address];
`else
  assign rd_word = mem[read_address];
`endif

  // Data stages only load on a valid beat so read_data holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else begin
      s1_valid <= rd_acc;
      if (rd_acc) s1_data <= rd_word;
      s2_valid <= s1_valid;
      if (s1_valid) s2_data <= s1_data;
    end
  end

  assign read_valid = (READ_LATENCY == 2) ? s2_valid : s1_valid;
  assign read_data  = (READ_LATENCY == 2) ? s2_data  : s1_data;

endmodule

// File: tb/tb_dpram_sync_clr.sv
// Scoreboard bench for dpram_sync_clr: latency-1 and latency-2 instances share stimulus.
module tb_dpram_sync_clr;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       clear_req = 1'b0;
  logic       we = 1'b0, re = 1'b0;
  logic [3:0] wa = '0, ra = '0;
  logic [7:0] wd = '0;

  logic       busy1, wrdy1, rrdy1, rv1;
  logic [7:0] rd1;
  logic       busy2, wrdy2, rrdy2, rv2;
  logic [7:0] rd2;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct { logic [7:0] d; int due; } exp_t;
  exp_t q1[$];
  exp_t q2[$];
  logic [7:0] model [16];
  logic [7:0] last1 = '0, last2 = '0;

  localparam logic [7:0] CV = 8'hA5;

  dpram_sync_clr #(.DATA_WIDTH(8), .ADDRESS_WIDTH(4), .READ_LATENCY(1), .CLEAR_VALUE(CV)) dut (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .busy(busy1),
    .write_enable(we), .write_address(wa), .write_data(wd), .write_ready(wrdy1),
    .read_enable(re), .read_address(ra), .read_ready(rrdy1),
    .read_data(rd1), .read_valid(rv1));

  dpram_sync_clr #(.DATA_WIDTH(8), .ADDRESS_WIDTH(4), .READ_LATENCY(2), .CLEAR_VALUE(CV)) dut2 (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .busy(busy2),
    .write_enable(we), .write_address(wa), .write_data(wd), .write_ready(wrdy2),
    .read_enable(re), .read_address(ra), .read_ready(rrdy2),
    .read_data(rd2), .read_valid(rv2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Pops expectations as valid beats appear; also flags missing beats and unheld data.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      last1 = '0;
      last2 = '0;
    end else begin
      vectors++;
      if (rv1) begin
        if (q1.size() == 0) begin
          miscompares++;
          $display("FAIL lat1_unexpected_valid: got data %h at cycle %0d, required no valid", rd1, cyc);
        end else begin
          e = q1.pop_front();
          if (rd1 !== e.d || cyc != e.due) begin
            miscompares++;
            $display("FAIL lat1_read: got %h at cycle %0d, required %h at cycle %0d", rd1, cyc, e.d, e.due);
          end
        end
        last1 = rd1;
      end else begin
        if (rd1 !== last1 || (q1.size() != 0 && q1[0].due <= cyc)) begin
          miscompares++;
          $display("FAIL lat1_idle: got data %h valid 0 at cycle %0d, required held %h and no pending beat", rd1, cyc, last1);
        end
      end
      vectors++;
      if (rv2) begin
        if (q2.size() == 0) begin
          miscompares++;
          $display("FAIL lat2_unexpected_valid: got data %h at cycle %0d, required no valid", rd2, cyc);
        end else begin
          e = q2.pop_front();
          if (rd2 !== e.d || cyc != e.due) begin
            miscompares++;
            $display("FAIL lat2_read: got %h at cycle %0d, required %h at cycle %0d", rd2, cyc, e.d, e.due);
          end
        end
        last2 = rd2;
      end else begin
        if (rd2 !== last2 || (q2.size() != 0 && q2[0].due <= cyc)) begin
          miscompares++;
          $display("FAIL lat2_idle: got data %h valid 0 at cycle %0d, required held %h and no pending beat", rd2, cyc, last2);
        end
      end
    end
  end

  // One cycle of stimulus; acc says whether the bench expects the ports to be ready.
  task automatic do_cycle(input logic w, input logic [3:0] a_w, input logic [7:0] d_w,
                          input logic r, input logic [3:0] a_r, input logic cr, input logic acc);
    exp_t e;
    we = w; wa = a_w; wd = d_w; re = r; ra = a_r; clear_req = cr;
    if (r && acc) begin
      e.d = model[a_r];
`ifdef DPRAM_BYPASS_EN
      if (w && a_w == a_r) e.d = d_w;
`endif
      e.due = cyc + 1;
      q1.push_back(e);
      e.due = cyc + 2;
      q2.push_back(e);
    end
    if (w && acc) model[a_w] = d_w;
    @(posedge clk);
    #1;
    we = 1'b0; re = 1'b0; clear_req = 1'b0;
  endtask

  task automatic idle(input int n);
    we = 1'b0; re = 1'b0; clear_req = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy1 && n < 100) begin
      @(negedge clk);
      if (busy1) n++;
    end
  endtask

  task automatic test_reset;
    int n;
    rst_n = 1'b0;
    q1.delete(); q2.delete();
    #3;
    vectors++;
    if ({busy1, wrdy1, rrdy1, rv1, rd1, busy2, wrdy2, rrdy2, rv2, rd2} !== {4'b1000, 8'h00, 4'b1000, 8'h00}) begin
      miscompares++;
      $display("FAIL reset_values: got %b %h / %b %h, required 1000 00 / 1000 00",
               {busy1, wrdy1, rrdy1, rv1}, rd1, {busy2, wrdy2, rrdy2, rv2}, rd2);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    count_busy(n);
    vectors++;
    if (n != 16 || busy2 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy_len: got %0d cycles (busy2 %b), required 16 (busy2 0)", n, busy2);
    end
    for (int i = 0; i < 16; i++) model[i] = CV;
    for (int unsigned i = 0; i < 16; i++) do_cycle(1'b0, '0, '0, 1'b1, 4'(i), 1'b0, 1'b1);
    idle(3);
  endtask

  task automatic test_write_read;
    do_cycle(1'b1, 4'd5, 8'h3C, 1'b0, '0, 1'b0, 1'b1);
    do_cycle(1'b0, '0, '0, 1'b1, 4'd5, 1'b0, 1'b1);
    idle(3);
    vectors++;
    if (rd1 !== 8'h3C || rd2 !== 8'h3C) begin
      miscompares++;
      $display("FAIL write_read_hold: got %h / %h, required 3c / 3c", rd1, rd2);
    end
  endtask

  task automatic test_same_cycle;
    do_cycle(1'b1, 4'd9, 8'h11, 1'b0, '0, 1'b0, 1'b1);
    do_cycle(1'b1, 4'd9, 8'h77, 1'b1, 4'd9, 1'b0, 1'b1);
    do_cycle(1'b0, '0, '0, 1'b1, 4'd9, 1'b0, 1'b1);
    idle(3);
  endtask

  task automatic test_clear;
    int n;
    for (int unsigned i = 0; i < 16; i++) do_cycle(1'b1, 4'(i), 8'hFF, 1'b0, '0, 1'b0, 1'b1);
    do_cycle(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) model[i] = CV;
    n = 0;
    while (busy1 && n < 100) begin
      we = 1'b1; wa = 4'(n); wd = 8'h00; re = 1'b1; ra = 4'(n); clear_req = (n == 7);
      @(negedge clk);
      if (busy1) n++;
      @(posedge clk); #1;
    end
    we = 1'b0; re = 1'b0; clear_req = 1'b0;
    vectors++;
    if (n != 16 || busy2 !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_busy_len: got %0d cycles (busy2 %b), required 16 (busy2 0)", n, busy2);
    end
    for (int unsigned i = 0; i < 16; i++) do_cycle(1'b0, '0, '0, 1'b1, 4'(i), 1'b0, 1'b1);
    idle(3);
  endtask

  task automatic test_reset_mid;
    int n;
    for (int unsigned i = 0; i < 16; i++) do_cycle(1'b1, 4'(i), 8'(i + 8'h40), 1'b0, '0, 1'b0, 1'b1);
    do_cycle(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b1);
    idle(7);
    rst_n = 1'b0;
    q1.delete(); q2.delete();
    #2;
    vectors++;
    if ({busy1, wrdy1, rrdy1, rv1, rd1, busy2, wrdy2, rrdy2, rv2, rd2} !== {4'b1000, 8'h00, 4'b1000, 8'h00}) begin
      miscompares++;
      $display("FAIL midreset_values: got %b %h / %b %h, required 1000 00 / 1000 00",
               {busy1, wrdy1, rrdy1, rv1}, rd1, {busy2, wrdy2, rrdy2, rv2}, rd2);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    count_busy(n);
    vectors++;
    if (n != 16) begin
      miscompares++;
      $display("FAIL midreset_busy_len: got %0d cycles, required 16", n);
    end
    for (int i = 0; i < 16; i++) model[i] = CV;
    for (int unsigned i = 0; i < 16; i++) do_cycle(1'b0, '0, '0, 1'b1, 4'(i), 1'b0, 1'b1);
    idle(3);
  endtask

  task automatic test_back_to_back;
    for (int unsigned i = 0; i < 16; i++) do_cycle(1'b1, 4'(i), 8'(i * 13 + 2), 1'b0, '0, 1'b0, 1'b1);
    for (int unsigned i = 0; i < 16; i++) do_cycle(1'b0, '0, '0, 1'b1, 4'(i), 1'b0, 1'b1);
    idle(4);
    vectors++;
    if (q1.size() != 0 || q2.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d / %0d pending reads, required 0 / 0", q1.size(), q2.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    #2;
    test_reset();
    test_write_read();
    test_same_cycle();
    test_clear();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
